// File: rtl/issue_queue_shift_ctrl.sv
// Compacting integer issue queue: oldest-ready select at the top index, one-hole-per-cycle
// compaction toward DEPTH-1, CDB wakeup on stored entries and on the dispatch slot.
module issue_queue_shift_ctrl #(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 6,
  parameter int DATA_W = 32,
  parameter int OPC_W  = 4,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dispatch_enable,
  output logic              dispatch_ready,
  input  logic [OPC_W-1:0]  dispatch_opcode,
  input  logic [TAG_W-1:0]  dispatch_rd_tag,
  input  logic [TAG_W-1:0]  dispatch_rs1_tag,
  input  logic [TAG_W-1:0]  dispatch_rs2_tag,
  input  logic [DATA_W-1:0] dispatch_rs1_data,
  input  logic [DATA_W-1:0] dispatch_rs2_data,
  input  logic              dispatch_rs1_data_val,
  input  logic              dispatch_rs2_data_val,
  input  logic [TAG_W-1:0]  CDB_tag,
  input  logic [DATA_W-1:0] CDB_data,
  input  logic              CDB_valid,
  output logic              issue_valid,
  input  logic              issue_ready,
  output logic [OPC_W-1:0]  issue_opcode,
  output logic [TAG_W-1:0]  issue_rd_tag,
  output logic [DATA_W-1:0] issue_rs1_data,
  output logic [DATA_W-1:0] issue_rs2_data,
  output logic              issueque_full,
  output logic [CNT_W-1:0]  issueque_count
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic [OPC_W-1:0]  opcode;
    logic [TAG_W-1:0]  rd_tag;
    logic [TAG_W-1:0]  rs1_tag;
    logic [TAG_W-1:0]  rs2_tag;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
  } payload_t;

  typedef struct packed {
    logic     valid;
    logic     rs1_rdy;
    logic     rs2_rdy;
    payload_t pl;
  } entry_t;

  logic [DEPTH-1:0] valid_q, rs1_rdy_q, rs2_rdy_q;
  payload_t         pl_q  [DEPTH];
  logic [CNT_W-1:0] cnt_q;

  entry_t           cur   [DEPTH];
  entry_t           woken [DEPTH];
  entry_t           nxt   [DEPTH];
  entry_t           disp;

  logic             sel_found, hole_found;
  logic [IDX_W-1:0] sel_idx, hole_idx;
  logic             issue_fire, dispatch_fire;

  function automatic entry_t wake(input entry_t e);
    entry_t r;
    r = e;
    if (CDB_valid && e.valid) begin
      if (!e.rs1_rdy && e.pl.rs1_tag == CDB_tag) begin
        r.rs1_rdy     = 1'b1;
        r.pl.rs1_data = CDB_data;
      end
      if (!e.rs2_rdy && e.pl.rs2_tag == CDB_tag) begin
        r.rs2_rdy     = 1'b1;
        r.pl.rs2_data = CDB_data;
      end
    end
    return r;
  endfunction

  // Ascending scans: the last hit wins, so both searches return the highest index.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    sel_found  = 1'b0;
    sel_idx    = '0;
    hole_found = 1'b0;
    hole_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cur[i] = '{valid: valid_q[i], rs1_rdy: rs1_rdy_q[i], rs2_rdy: rs2_rdy_q[i], pl: pl_q[i]};
      if (valid_q[i] && rs1_rdy_q[i] && rs2_rdy_q[i]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
    issue_fire = sel_found && issue_ready;
    for (int i = 0; i < DEPTH; i++) begin
      if (!valid_q[i] || (issue_fire && sel_idx == IDX_W'(i))) begin
        hole_found = 1'b1;
        hole_idx   = IDX_W'(i);
      end
    end
  end

  assign dispatch_ready = hole_found;
  assign dispatch_fire  = dispatch_enable && hole_found;

  always_comb begin
    disp = '{valid:   dispatch_fire,
             rs1_rdy: dispatch_rs1_data_val,
             rs2_rdy: dispatch_rs2_data_val,
             pl:      '{opcode:   dispatch_opcode,
                        rd_tag:   dispatch_rd_tag,
                        rs1_tag:  dispatch_rs1_tag,
                        rs2_tag:  dispatch_rs2_tag,
                        rs1_data: dispatch_rs1_data,
                        rs2_data: dispatch_rs2_data}};
    disp = wake(disp);
    for (int i = 0; i < DEPTH; i++) begin
      woken[i] = wake(cur[i]);
      // The issued entry turns into a bubble so a shift from below cannot resurrect it.
      if (issue_fire && sel_idx == IDX_W'(i)) woken[i].valid = 1'b0;
    end
    nxt[0] = hole_found ? disp : woken[0];
    for (int i = 1; i < DEPTH; i++) begin
      nxt[i] = (hole_found && IDX_W'(i) <= hole_idx) ? woken[i-1] : woken[i];
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= '0;
      rs1_rdy_q <= '0;
      rs2_rdy_q <= '0;
      cnt_q     <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i]   <= nxt[i].valid;
        rs1_rdy_q[i] <= nxt[i].rs1_rdy;
        rs2_rdy_q[i] <= nxt[i].rs2_rdy;
      end
      cnt_q <= cnt_q + CNT_W'(dispatch_fire) - CNT_W'(issue_fire);
    end
  end

  // NOTE: payload storage has no reset; valid bits alone guard its use, keeping it plain RAM-like flops.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) pl_q[i] <= nxt[i].pl;
  end

  assign issue_valid    = sel_found;
  assign issue_opcode   = sel_found ? pl_q[sel_idx].opcode   : '0;
  assign issue_rd_tag   = sel_found ? pl_q[sel_idx].rd_tag   : '0;
  assign issue_rs1_data = sel_found ? pl_q[sel_idx].rs1_data : '0;
  assign issue_rs2_data = sel_found ? pl_q[sel_idx].rs2_data : '0;
  assign issueque_full  = (cnt_q == CNT_W'(DEPTH));
  assign issueque_count = cnt_q;

endmodule

// File: tb/tb_issue_queue_shift_ctrl.sv
// Directed bench for issue_queue_shift_ctrl: vector table checked just before each edge,
// then a hand-written full/ignored-dispatch/broadcast-wakeup/drain sequence.
module tb_issue_queue_shift_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        dispatch_enable, dispatch_ready;
  logic [3:0]  dispatch_opcode;
  logic [5:0]  dispatch_rd_tag, dispatch_rs1_tag, dispatch_rs2_tag;
  logic [31:0] dispatch_rs1_data, dispatch_rs2_data;
  logic        dispatch_rs1_data_val, dispatch_rs2_data_val;
  logic [5:0]  CDB_tag;
  logic [31:0] CDB_data;
  logic        CDB_valid;
  logic        issue_valid, issue_ready;
  logic [3:0]  issue_opcode;
  logic [5:0]  issue_rd_tag;
  logic [31:0] issue_rs1_data, issue_rs2_data;
  logic        issueque_full;
  logic [2:0]  issueque_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  issue_queue_shift_ctrl dut (
    .clk                   (clk),
    .reset                 (reset),
    .dispatch_enable       (dispatch_enable),
    .dispatch_ready        (dispatch_ready),
    .dispatch_opcode       (dispatch_opcode),
    .dispatch_rd_tag       (dispatch_rd_tag),
    .dispatch_rs1_tag      (dispatch_rs1_tag),
    .dispatch_rs2_tag      (dispatch_rs2_tag),
    .dispatch_rs1_data     (dispatch_rs1_data),
    .dispatch_rs2_data     (dispatch_rs2_data),
    .dispatch_rs1_data_val (dispatch_rs1_data_val),
    .dispatch_rs2_data_val (dispatch_rs2_data_val),
    .CDB_tag               (CDB_tag),
    .CDB_data              (CDB_data),
    .CDB_valid             (CDB_valid),
    .issue_valid           (issue_valid),
    .issue_ready           (issue_ready),
    .issue_opcode          (issue_opcode),
    .issue_rd_tag          (issue_rd_tag),
    .issue_rs1_data        (issue_rs1_data),
    .issue_rs2_data        (issue_rs2_data),
    .issueque_full         (issueque_full),
    .issueque_count        (issueque_count)
  );

  typedef struct {
    logic        rst, de;
    logic [3:0]  opc;
    logic [5:0]  rd, t1, t2;
    logic [31:0] d1, d2;
    logic        v1, v2, cv;
    logic [5:0]  ct;
    logic [31:0] cd;
    logic        ir;
    logic        ev;
    logic [3:0]  eopc;
    logic [5:0]  erd;
    logic [31:0] ed1, ed2;
    logic [2:0]  ecnt;
    logic        efull, edr;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset                 = v.rst;
    dispatch_enable       = v.de;
    dispatch_opcode       = v.opc;
    dispatch_rd_tag       = v.rd;
    dispatch_rs1_tag      = v.t1;
    dispatch_rs2_tag      = v.t2;
    dispatch_rs1_data     = v.d1;
    dispatch_rs2_data     = v.d2;
    dispatch_rs1_data_val = v.v1;
    dispatch_rs2_data_val = v.v2;
    CDB_valid             = v.cv;
    CDB_tag               = v.ct;
    CDB_data              = v.cd;
    issue_ready           = v.ir;
  endtask

  task automatic idle();
    vec_t z;
    z = '{default: '0};
    drive(z);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("reset issue_valid", 32'(issue_valid), 32'd0);
    check("reset count", 32'(issueque_count), 32'd0);
    check("reset full", 32'(issueque_full), 32'd0);
    check("reset dispatch_ready", 32'(dispatch_ready), 32'd1);
    check("reset issue_opcode", 32'(issue_opcode), 32'd0);

    //          rst de opc   rd     t1     t2     d1            d2            v1 v2 cv ct     cd            ir | ev eopc  erd    ed1           ed2           cnt  full dr
    // Fill four ready entries, then full with issue stalled.
    vecs.push_back('{0,1,4'h1,6'h01,6'h00,6'h00,32'h11,32'h12,1,1,0,6'h00,32'h0,0, 0,4'h0,6'h00,32'h0,32'h0,3'd0,0,1});
    vecs.push_back('{0,1,4'h2,6'h02,6'h00,6'h00,32'h21,32'h22,1,1,0,6'h00,32'h0,0, 1,4'h1,6'h01,32'h11,32'h12,3'd1,0,1});
    vecs.push_back('{0,1,4'h3,6'h03,6'h00,6'h00,32'h31,32'h32,1,1,0,6'h00,32'h0,0, 1,4'h1,6'h01,32'h11,32'h12,3'd2,0,1});
    vecs.push_back('{0,1,4'h4,6'h04,6'h00,6'h00,32'h41,32'h42,1,1,0,6'h00,32'h0,0, 1,4'h1,6'h01,32'h11,32'h12,3'd3,0,1});
    vecs.push_back('{0,0,4'h0,6'h00,6'h00,6'h00,32'h0,32'h0,0,0,0,6'h00,32'h0,0, 1,4'h1,6'h01,32'h11,32'h12,3'd4,1,0});
    // Full queue: dispatch and issue together, then drain to check order.
    vecs.push_back('{0,1,4'h5,6'h05,6'h00,6'h00,32'h51,32'h52,1,1,0,6'h00,32'h0,1, 1,4'h1,6'h01,32'h11,32'h12,3'd4,1,1});
    vecs.push_back('{0,0,4'h0,6'h00,6'h00,6'h00,32'h0,32'h0,0,0,0,6'h00,32'h0,1, 1,4'h2,6'h02,32'h21,32'h22,3'd4,1,1});
    vecs.push_back('{0,0,4'h0,6'h00,6'h00,6'h00,32'h0,32'h0,0,0,0,6'h00,32'h0,1, 1,4'h3,6'h03,32'h31,32'h32,3'd3,0,1});
    vecs.push_back('{0,0,4'h0,6'h00,6'h00,6'h00,32'h0,32'h0,0,0,0,6'h00,32'h0,1, 1,4'h4,6'h04,32'h41,32'h42,3'd2,0,1});
    vecs.push_back('{0,0,4'h0,6'h00,6'h00,6'h00,32'h0,32'h0,0,0,0,6'h00,32'h0,1, 1,4'h5,6'h05,32'h51,32'h52,3'd1,0,1});
    // rs1 waits on tag 15, CDB wakes it while it shifts, issue one cycle later.
    vecs.push_back('{0,1,4'h6,6'h06,6'h15,6'h00,32'h0,32'h62,0,1,0,6'h00,32'h0,1, 0,4'h0,6'h00,32'h0,32'h0,3'd0,0,1});
    vecs.push_back('{0,0,4'h0,6'h00,6'h00,6'h00,32'h0,32'h0,0,0,1,6'h15,32'hDEADBEEF,1, 0,4'h0,6'h00,32'h0,32'h0,3'd1,0,1});
    vecs.push_back('{0,0,4'h0,6'h00,6'h00,6'h00,32'h0,32'h0,0,0,0,6'h00,32'h0,1, 1,4'h6,6'h06,32'hDEADBEEF,32'h62,3'd1,0,1});
    // Dispatch-time wakeup of rs2 on tag 0A.
    vecs.push_back('{0,1,4'h7,6'h07,6'h00,6'h0A,32'h71,32'h0,1,0,1,6'h0A,32'hCAFE0A0A,0, 0,4'h0,6'h00,32'h0,32'h0,3'd0,0,1});
    vecs.push_back('{0,0,4'h0,6'h00,6'h00,6'h00,32'h0,32'h0,0,0,0,6'h00,32'h0,1, 1,4'h7,6'h07,32'h71,32'hCAFE0A0A,3'd1,0,1});
    // Slots 3 and 1 waiting, slot 2 ready; issue from the middle with a CDB for slot 1.
    vecs.push_back('{0,1,4'h8,6'h08,6'h21,6'h00,32'h0,32'h82,0,1,0,6'h00,32'h0,0, 0,4'h0,6'h00,32'h0,32'h0,3'd0,0,1});
    vecs.push_back('{0,1,4'h9,6'h09,6'h00,6'h00,32'h91,32'h92,1,1,0,6'h00,32'h0,0, 0,4'h0,6'h00,32'h0,32'h0,3'd1,0,1});
    vecs.push_back('{0,1,4'hA,6'h0A,6'h00,6'h33,32'hA1,32'h0,1,0,0,6'h00,32'h0,0, 1,4'h9,6'h09,32'h91,32'h92,3'd2,0,1});
    vecs.push_back('{0,1,4'hB,6'h0B,6'h00,6'h00,32'hB1,32'hB2,1,1,0,6'h00,32'h0,0, 1,4'h9,6'h09,32'h91,32'h92,3'd3,0,1});
    vecs.push_back('{0,0,4'h0,6'h00,6'h00,6'h00,32'h0,32'h0,0,0,1,6'h33,32'h33333333,1, 1,4'h9,6'h09,32'h91,32'h92,3'd4,1,1});
    vecs.push_back('{0,0,4'h0,6'h00,6'h00,6'h00,32'h0,32'h0,0,0,0,6'h00,32'h0,0, 1,4'hA,6'h0A,32'hA1,32'h33333333,3'd3,0,1});
    // Reset with dispatch, issue and a CDB all active.
    vecs.push_back('{1,1,4'hC,6'h0C,6'h00,6'h00,32'hC1,32'hC2,1,1,1,6'h21,32'h21212121,1, 1,4'hA,6'h0A,32'hA1,32'h33333333,3'd3,0,1});
    vecs.push_back('{0,0,4'h0,6'h00,6'h00,6'h00,32'h0,32'h0,0,0,0,6'h00,32'h0,0, 0,4'h0,6'h00,32'h0,32'h0,3'd0,0,1});

    foreach (vecs[k]) begin
      drive(vecs[k]);
      #1;
      check($sformatf("v%0d issue_valid", k), 32'(issue_valid), 32'(vecs[k].ev));
      check($sformatf("v%0d issue_opcode", k), 32'(issue_opcode), 32'(vecs[k].eopc));
      check($sformatf("v%0d issue_rd_tag", k), 32'(issue_rd_tag), 32'(vecs[k].erd));
      check($sformatf("v%0d issue_rs1_data", k), issue_rs1_data, vecs[k].ed1);
      check($sformatf("v%0d issue_rs2_data", k), issue_rs2_data, vecs[k].ed2);
      check($sformatf("v%0d count", k), 32'(issueque_count), 32'(vecs[k].ecnt));
      check($sformatf("v%0d full", k), 32'(issueque_full), 32'(vecs[k].efull));
      check($sformatf("v%0d dispatch_ready", k), 32'(dispatch_ready), 32'(vecs[k].edr));
      tick();
    end

    // Fill with four entries all waiting on tag 3F.
    idle();
    for (int n = 0; n < 4; n++) begin
      dispatch_enable   = 1'b1;
      dispatch_opcode   = 4'(n + 1);
      dispatch_rd_tag   = 6'(n + 16);
      dispatch_rs1_tag  = 6'h3F;
      dispatch_rs2_data = 32'(n);
      dispatch_rs2_data_val = 1'b1;
      #1;
      check($sformatf("fill%0d dispatch_ready", n), 32'(dispatch_ready), 32'd1);
      tick();
    end
    // Dispatch against a full queue must be dropped.
    dispatch_opcode = 4'hF;
    #1;
    check("full dispatch_ready", 32'(dispatch_ready), 32'd0);
    check("full count", 32'(issueque_count), 32'd4);
    tick();
    idle();
    CDB_valid = 1'b1;
    CDB_tag   = 6'h3F;
    CDB_data  = 32'h5A5A5A5A;
    #1;
    check("no same-cycle bypass", 32'(issue_valid), 32'd0);
    check("ignored dispatch count", 32'(issueque_count), 32'd4);
    tick();
    idle();
    issue_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      #1;
      check($sformatf("drain%0d issue_valid", n), 32'(issue_valid), 32'd1);
      check($sformatf("drain%0d issue_opcode", n), 32'(issue_opcode), 32'(n + 1));
      check($sformatf("drain%0d issue_rd_tag", n), 32'(issue_rd_tag), 32'(n + 16));
      check($sformatf("drain%0d issue_rs1_data", n), issue_rs1_data, 32'h5A5A5A5A);
      check($sformatf("drain%0d issue_rs2_data", n), issue_rs2_data, 32'(n));
      check($sformatf("drain%0d count", n), 32'(issueque_count), 32'(4 - n));
      tick();
    end
    #1;
    check("drained issue_valid", 32'(issue_valid), 32'd0);
    check("drained count", 32'(issueque_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
